// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM backprop datapath: FSM encoding and
// default network dimensions.
package lstm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int LSTM_HID   = 53;
    localparam int LSTM_GATES = 4;

endpackage

// File: rtl/wu_nest_cnt.sv
// Column/row nested counter for the weight-update walk. Reports terminal
// flags for both the current and the about-to-be-registered count.
module wu_nest_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 step,
    input  logic [CNT_WIDTH-1:0] col_lim,
    input  logic [CNT_WIDTH-1:0] row_lim,
    output logic                 col_end,
    output logic                 row_end,
    output logic                 col_nxt_end,
    output logic                 row_nxt_end
);

    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic [CNT_WIDTH-1:0] col_max_s, row_max_s;

    assign col_max_s   = col_lim - CNT_WIDTH'(1);
    assign row_max_s   = row_lim - CNT_WIDTH'(1);
    assign col_end     = (col_q == col_max_s);
    assign row_end     = (row_q == row_max_s);
    assign col_nxt_end = (col_d == col_max_s);
    assign row_nxt_end = (row_d == row_max_s);

    // next column/row: clear wins over step, row wraps after its last value
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + CNT_WIDTH'(1);
                end
            end else begin
                col_d = col_q + CNT_WIDTH'(1);
            end
        end else begin
            col_d = col_q;
        end
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/addr_gen_wu_mc.sv
// Multi-channel weight-update address generator: walks NUM_CH row-major
// matrices with a programmable bubble after every row.
module addr_gen_wu_mc
    import lstm_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CH_WIDTH   = 2,
    parameter int NUM_CH     = LSTM_GATES,
    parameter int CH_STRIDE  = LSTM_HID * LSTM_HID,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  en,
    input  logic                  cont,
    input  logic [CNT_WIDTH-1:0]  row_len,
    input  logic [CNT_WIDTH-1:0]  num_rows,
    input  logic [CNT_WIDTH-1:0]  pause_len,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [CH_WIDTH-1:0]   o_ch,
    output logic                  o_valid,
    output logic                  o_row_last,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [CH_WIDTH-1:0]   LAST_CH = CH_WIDTH'(NUM_CH - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(CH_STRIDE);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [CNT_WIDTH-1:0]  pause_q, pause_d;
    logic [CNT_WIDTH-1:0]  rl_q, rl_d, nr_q, nr_d, pl_q, pl_d;
    logic                  cont_q, cont_d;
    logic                  valid_q, valid_d, row_last_q, row_last_d;
    logic                  last_q, last_d, busy_q, busy_d, done_q, done_d;

    logic                  start_s, restart_s, cnt_clr_s, cnt_step_s;
    logic [CNT_WIDTH-1:0]  col_lim_s, row_lim_s;
    logic                  col_end_s, row_end_s, col_nxt_end_s, row_nxt_end_s;

    // While idle the counter must see the incoming cfg, since it is latched on the same edge.
    assign start_s    = start && (state_q == ST_IDLE) && !abort;
    assign restart_s  = (state_q == ST_DONE) && done_q && cont_q && !abort;
    assign cnt_clr_s  = abort || start_s || restart_s;
    assign cnt_step_s = (state_q == ST_RUN) && en && !last_q && !abort;
    assign col_lim_s  = (state_q == ST_IDLE) ? row_len  : rl_q;
    assign row_lim_s  = (state_q == ST_IDLE) ? num_rows : nr_q;

    wu_nest_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_nest_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr_s),
        .step        (cnt_step_s),
        .col_lim     (col_lim_s),
        .row_lim     (row_lim_s),
        .col_end     (col_end_s),
        .row_end     (row_end_s),
        .col_nxt_end (col_nxt_end_s),
        .row_nxt_end (row_nxt_end_s)
    );

    // FSM, channel/pause counters and next values of every registered output
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        ch_d       = ch_q;
        pause_d    = pause_q;
        rl_d       = rl_q;
        nr_d       = nr_q;
        pl_d       = pl_q;
        cont_d     = cont_q;
        valid_d    = valid_q;
        row_last_d = row_last_q;
        last_d     = last_q;
        done_d     = 1'b0;
        if (abort) begin
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            row_last_d = 1'b0;
            last_d     = 1'b0;
            pause_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        rl_d    = row_len;
                        nr_d    = num_rows;
                        pl_d    = pause_len;
                        cont_d  = cont;
                        addr_d  = '0;
                        base_d  = '0;
                        ch_d    = '0;
                        pause_d = '0;
                        if ((row_len == '0) || (num_rows == '0)) begin
                            state_d    = ST_DONE;
                            valid_d    = 1'b0;
                            row_last_d = 1'b0;
                            last_d     = 1'b0;
                        end else begin
                            state_d    = ST_RUN;
                            valid_d    = 1'b1;
                            row_last_d = col_nxt_end_s;
                            last_d     = col_nxt_end_s && row_nxt_end_s && (ch_d == LAST_CH);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_RUN;
                    end else if (last_q) begin
                        state_d    = ST_DONE;
                        valid_d    = 1'b0;
                        row_last_d = 1'b0;
                        last_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        if (col_end_s && row_end_s) begin
                            ch_d   = ch_q + CH_WIDTH'(1);
                            base_d = base_q + STRIDE;
                            addr_d = base_q + STRIDE;
                        end else begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                        if (col_end_s && (pl_q != '0)) begin
                            state_d    = ST_PAUSE;
                            valid_d    = 1'b0;
                            row_last_d = 1'b0;
                            last_d     = 1'b0;
                            pause_d    = '0;
                        end else begin
                            valid_d    = 1'b1;
                            row_last_d = col_nxt_end_s;
                            last_d     = col_nxt_end_s && row_nxt_end_s && (ch_d == LAST_CH);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!en) begin
                        state_d = ST_PAUSE;
                    end else if (pause_q == (pl_q - CNT_WIDTH'(1))) begin
                        state_d    = ST_RUN;
                        pause_d    = '0;
                        valid_d    = 1'b1;
                        row_last_d = col_end_s;
                        last_d     = col_end_s && row_end_s && (ch_q == LAST_CH);
                    end else begin
                        pause_d = pause_q + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    // An empty pass enters DONE with done low, so it pulses here one cycle late.
                    if (!done_q) begin
                        done_d = 1'b1;
                    end else if (cont_q) begin
                        addr_d = '0;
                        base_d = '0;
                        ch_d   = '0;
                        if ((rl_q == '0) || (nr_q == '0)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_RUN;
                            valid_d    = 1'b1;
                            row_last_d = col_nxt_end_s;
                            last_d     = col_nxt_end_s && row_nxt_end_s && (ch_d == LAST_CH);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    valid_d    = 1'b0;
                    row_last_d = 1'b0;
                    last_d     = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // state, cfg and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            ch_q       <= '0;
            pause_q    <= '0;
            rl_q       <= '0;
            nr_q       <= '0;
            pl_q       <= '0;
            cont_q     <= 1'b0;
            valid_q    <= 1'b0;
            row_last_q <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            ch_q       <= ch_d;
            pause_q    <= pause_d;
            rl_q       <= rl_d;
            nr_q       <= nr_d;
            pl_q       <= pl_d;
            cont_q     <= cont_d;
            valid_q    <= valid_d;
            row_last_q <= row_last_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_addr     = addr_q;
    assign o_ch       = ch_q;
    assign o_valid    = valid_q;
    assign o_row_last = row_last_q;
    assign o_last     = last_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_addr_gen_wu_mc.sv
// Directed bench for addr_gen_wu_mc: a single-channel and a four-channel
// instance share stimulus; each scenario checks the instance it targets.
module tb_addr_gen_wu_mc;

    logic        clk = 1'b0;
    logic        rst, start, abort, en, cont;
    logic [7:0]  row_len, num_rows, pause_len;

    logic [11:0] d1_addr, d4_addr;
    logic [1:0]  d1_ch, d4_ch;
    logic        d1_valid, d1_row_last, d1_last, d1_busy, d1_done;
    logic        d4_valid, d4_row_last, d4_last, d4_busy, d4_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_gen_wu_mc #(.NUM_CH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .cont(cont),
        .row_len(row_len), .num_rows(num_rows), .pause_len(pause_len),
        .o_addr(d1_addr), .o_ch(d1_ch), .o_valid(d1_valid), .o_row_last(d1_row_last),
        .o_last(d1_last), .o_busy(d1_busy), .o_done(d1_done)
    );

    addr_gen_wu_mc #(.NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en), .cont(cont),
        .row_len(row_len), .num_rows(num_rows), .pause_len(pause_len),
        .o_addr(d4_addr), .o_ch(d4_ch), .o_valid(d4_valid), .o_row_last(d4_row_last),
        .o_last(d4_last), .o_busy(d4_busy), .o_done(d4_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input logic [7:0] rl, input logic [7:0] nr, input logic [7:0] pl,
                        input logic c);
        start = 1'b0; en = 1'b1; cont = c;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        row_len = rl; num_rows = nr; pause_len = pl;
    endtask

    task automatic kick;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; en = 1'b0; cont = 1'b0;
        row_len = 8'd0; num_rows = 8'd0; pause_len = 8'd0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({d4_addr, d4_ch, d4_valid, d4_row_last, d4_last, d4_busy, d4_done} !== 19'd0) begin
            failures++;
            $display("FAIL reset_dut4: got addr=%0d ch=%0d v=%b rl=%b l=%b b=%b d=%b expected all 0",
                     d4_addr, d4_ch, d4_valid, d4_row_last, d4_last, d4_busy, d4_done);
        end
        checks++;
        if ({d1_addr, d1_valid, d1_busy, d1_done} !== 15'd0) begin
            failures++;
            $display("FAIL reset_dut1: got addr=%0d v=%b b=%b d=%b expected all 0",
                     d1_addr, d1_valid, d1_busy, d1_done);
        end
    endtask

    task automatic test_full_53;
        int err = 0, exp_a = 0, bub = 0;
        bit fin = 0;
        logic exp_rl, exp_l;
        prep(8'd53, 8'd53, 8'd2, 1'b0);
        kick();
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (bub > 0) begin
                if (d1_valid !== 1'b0) begin
                    if (err == 0) $display("FAIL seq53_bubble: got valid=%b expected 0 after addr %0d", d1_valid, exp_a - 1);
                    err++;
                end
                bub--;
            end else begin
                exp_rl = (exp_a % 53 == 52);
                exp_l  = (exp_a == 2808);
                if (d1_valid !== 1'b1 || d1_addr !== 12'(exp_a) || d1_row_last !== exp_rl || d1_last !== exp_l) begin
                    if (err == 0) $display("FAIL seq53_addr: got v=%b addr=%0d rl=%b l=%b expected v=1 addr=%0d rl=%b l=%b",
                                           d1_valid, d1_addr, d1_row_last, d1_last, exp_a, exp_rl, exp_l);
                    err++;
                end
                if (exp_l) fin = 1;
                else begin
                    if (exp_rl) bub = 2;
                    exp_a++;
                end
            end
            if (!fin) tick();
        end
        checks++;
        if (err !== 0 || fin !== 1'b1) begin
            failures++;
            $display("FAIL seq53: got %0d errors, reached_last=%0d, expected 0 errors and 1", err, fin);
        end
        tick();
        checks++;
        if (d1_done !== 1'b1 || d1_valid !== 1'b0) begin
            failures++;
            $display("FAIL done53: got done=%b valid=%b expected done=1 valid=0", d1_done, d1_valid);
        end
        tick();
        checks++;
        if (d1_done !== 1'b0 || d1_busy !== 1'b0) begin
            failures++;
            $display("FAIL done53_pulse: got done=%b busy=%b expected 0 0", d1_done, d1_busy);
        end
    endtask

    task automatic test_multi_ch;
        int err = 0;
        logic [11:0] ea, a27;
        prep(8'd3, 8'd3, 8'd0, 1'b0);
        kick();
        for (int i = 0; i < 36; i++) begin
            ea = 12'(((i / 9) * 2809 + (i % 9)) % 4096);
            if (i == 27) a27 = d4_addr;
            if (d4_valid !== 1'b1 || d4_addr !== ea || d4_ch !== 2'(i / 9) || d4_last !== (i == 35)) begin
                if (err == 0) $display("FAIL multi_seq: step %0d got v=%b addr=%0d ch=%0d l=%b expected v=1 addr=%0d ch=%0d",
                                       i, d4_valid, d4_addr, d4_ch, d4_last, ea, i / 9);
                err++;
            end
            tick();
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL multi_seq: got %0d errors expected 0", err);
        end
        checks++;
        if (a27 !== 12'd235) begin
            failures++;
            $display("FAIL multi_ch3_base: got %0d expected 235", a27);
        end
        checks++;
        if (d4_done !== 1'b1) begin
            failures++;
            $display("FAIL multi_done: got %b expected 1", d4_done);
        end
    endtask

    task automatic test_random_en;
        logic [11:0] exp_q[32];
        logic [11:0] hold_addr;
        logic [1:0]  hold_ch;
        bit hold = 0, seen_done = 0;
        int k = 0, err = 0;
        for (int i = 0; i < 32; i++) exp_q[i] = 12'(((i / 8) * 2809 + (i % 8)) % 4096);
        prep(8'd4, 8'd2, 8'd1, 1'b0);
        kick();
        for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            if (hold && (d4_valid !== 1'b1 || d4_addr !== hold_addr || d4_ch !== hold_ch)) begin
                if (err == 0) $display("FAIL stall_hold: got v=%b addr=%0d expected v=1 addr=%0d", d4_valid, d4_addr, hold_addr);
                err++;
            end
            if (d4_done === 1'b1) begin
                seen_done = 1;
            end else begin
                en = 1'($urandom_range(0, 1));
                hold = 0;
                if (d4_valid === 1'b1 && en) begin
                    if (k >= 32 || d4_addr !== exp_q[k]) begin
                        if (err == 0) $display("FAIL consumed: index %0d got %0d expected %0d", k, d4_addr, (k < 32) ? exp_q[k] : 12'hfff);
                        err++;
                    end
                    k++;
                end else begin
                    hold = d4_valid;
                    hold_addr = d4_addr;
                    hold_ch = d4_ch;
                end
                tick();
            end
        end
        en = 1'b1;
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL random_en: got %0d errors expected 0", err);
        end
        checks++;
        if (k !== 32 || seen_done !== 1'b1) begin
            failures++;
            $display("FAIL random_en_count: got %0d consumed done=%0d expected 32 and 1", k, seen_done);
        end
    endtask

    task automatic test_abort;
        prep(8'd3, 8'd3, 8'd0, 1'b0);
        kick();
        tick(); tick(); tick(); tick();
        checks++;
        if (d4_addr !== 12'd4 || d4_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: got addr=%0d v=%b expected 4 1", d4_addr, d4_valid);
        end
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        checks++;
        if (d4_valid !== 1'b0 || d4_busy !== 1'b0 || d4_done !== 1'b0) begin
            failures++;
            $display("FAIL abort: got v=%b b=%b d=%b expected 0 0 0", d4_valid, d4_busy, d4_done);
        end
        tick(); tick();
        checks++;
        if (d4_done !== 1'b0 || d4_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got d=%b b=%b expected 0 0", d4_done, d4_busy);
        end
        kick();
        checks++;
        if (d4_valid !== 1'b1 || d4_addr !== 12'd0 || d4_ch !== 2'd0) begin
            failures++;
            $display("FAIL abort_restart: got v=%b addr=%0d ch=%0d expected 1 0 0", d4_valid, d4_addr, d4_ch);
        end
    endtask

    task automatic test_zero_len;
        prep(8'd0, 8'd3, 8'd0, 1'b0);
        kick();
        checks++;
        if (d4_done !== 1'b0 || d4_valid !== 1'b0 || d4_busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_c1: got d=%b v=%b b=%b expected 0 0 1", d4_done, d4_valid, d4_busy);
        end
        tick();
        checks++;
        if (d4_done !== 1'b1 || d4_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_c2: got d=%b v=%b expected 1 0", d4_done, d4_valid);
        end
        tick();
        checks++;
        if (d4_done !== 1'b0 || d4_valid !== 1'b0 || d4_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_c3: got d=%b v=%b b=%b expected 0 0 0", d4_done, d4_valid, d4_busy);
        end
    endtask

    task automatic test_cont;
        logic       pv[6];
        logic [11:0] pa[6];
        logic       pd[6];
        int err = 0;
        pv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pa = '{12'd0, 12'd1, 12'd0, 12'd2, 12'd3, 12'd0};
        pd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        prep(8'd2, 8'd2, 8'd1, 1'b1);
        kick();
        for (int i = 0; i < 12; i++) begin
            if (d1_valid !== pv[i % 6] || d1_done !== pd[i % 6] || (pv[i % 6] && d1_addr !== pa[i % 6])) begin
                if (err == 0) $display("FAIL cont_seq: cycle %0d got v=%b addr=%0d d=%b expected v=%b addr=%0d d=%b",
                                       i, d1_valid, d1_addr, d1_done, pv[i % 6], pa[i % 6], pd[i % 6]);
                err++;
            end
            tick();
        end
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL cont_seq: got %0d errors expected 0", err);
        end
        tick(); tick();
        checks++;
        if (d1_valid !== 1'b0 || d1_busy !== 1'b1) begin
            failures++;
            $display("FAIL cont_pause: got v=%b b=%b expected 0 1", d1_valid, d1_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({d1_addr, d1_ch, d1_valid, d1_row_last, d1_last, d1_busy, d1_done} !== 19'd0) begin
            failures++;
            $display("FAIL cont_rst: got addr=%0d v=%b b=%b d=%b expected all 0", d1_addr, d1_valid, d1_busy, d1_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_53();
        test_multi_ch();
        test_random_en();
        test_abort();
        test_zero_len();
        test_cont();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
